cla_sub16_pipe: RTL
===================

CLA_SUB16_PIPE -- requirements
Module: cla_sub16_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 4.
REQ-002 Port clk  input  1  single clock, all state on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1  operand set presented.
REQ-005 Port in_ready  output  1  block can accept an operand set this cycle.
REQ-006 Port a  input  WIDTH  minuend.
REQ-007 Port b  input  WIDTH  subtrahend.
REQ-008 Port bin  input  1  borrow in.
REQ-009 Port out_valid  output  1  result presented.
REQ-010 Port out_ready  input  1  downstream accepts result.
REQ-011 Port diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 Port bout  output  1  borrow out: 1 when a < b + bin, unsigned.
REQ-013 Port ovf  output  1  two's-complement overflow of the subtraction.
REQ-014 Port zero  output  1  diff == 0.

Function
REQ-015 Subtraction SHALL be computed as a + ~b + carry_in, with carry_in = ~bin and bout = ~carry_out.
REQ-016 ovf SHALL equal (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]).
REQ-017 Datapath SHALL have WIDTH/4 pipeline stages, each resolving one 4-bit slice (LSB slice first) with lookahead generate/propagate and registering the slice carry into the next stage.
REQ-018 Unconsumed operand bits SHALL travel in skew registers alongside the valid bit; completed difference slices SHALL travel in de-skew registers so diff leaves aligned.
REQ-019 Global advance = !out_valid OR out_ready; in_ready SHALL equal advance, combinationally.
REQ-020 Transfer on rising edge where in_valid AND in_ready; with no stall its result SHALL be presented (out_valid=1) after edge k+WIDTH/4-1 (4 edges for WIDTH=16, k = accept edge).
REQ-021 When advance=0 every stage register, valid bit and output SHALL hold; no result is dropped or duplicated.
REQ-022 Throughput: one result per cycle while out_ready=1 and in_valid=1.
REQ-023 Results SHALL leave in acceptance order.
REQ-024 Empty stages (valid bit 0) SHALL advance as bubbles; bubbles SHALL NOT raise out_valid.
REQ-025 diff, bout, ovf, zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Inputs with in_valid=0 SHALL NOT affect state.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits; out_valid=0, diff=0, bout=0, ovf=0, zero=0.
REQ-028 Reset mid-operation SHALL discard all in-flight results; in_ready=1 from the first cycle after rst_n deasserts.
REQ-029 Datapath registers MAY be cleared by reset; they SHALL be cleared where they drive outputs.

Structure
REQ-030 Package cla_pkg SHALL hold SLICE_W=4 and the per-stage record type (valid, carry, skewed operands, partial diff).
REQ-031 One sub-module, cla4_slice: combinational 4-bit lookahead slice (a, b, cin -> sum, cout, group P/G), instantiated once per stage.
REQ-032 No behavioural "-" operator in the datapath; arithmetic SHALL use cla4_slice only.

Verification
REQ-033 a=0x0005, b=0x0003, bin=0 -> diff=0x0002, bout=0, ovf=0, zero=0, out_valid 4 edges after accept.
REQ-034 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
REQ-035 a=0x1234, b=0x1233, bin=1 -> diff=0x0000, zero=1, bout=0; a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
REQ-036 Stream 8 back-to-back sets, out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid=1 and out_ready=0; 8 results, in order, none lost.
REQ-037 rst_n pulsed low with 3 results in flight -> out_valid=0 immediately, no stale result ever emitted; next accepted set returns correct result after 4 edges.
REQ-038 Random 10k sets with random in_valid/out_ready -> every result matches scoreboard model (a - b - bin), order preserved.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: slice width and the per-stage pipeline record shared by the subtractor pipeline
package cla_pkg;
  localparam int SLICE_W = 4;
  localparam int MAX_W = 64;
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
    logic [MAX_W-1:0] diff;
  } stage_t;
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice with group propagate/generate
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               grp_p,
  output logic               grp_g
);
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cout = grp_g | (grp_p & cin);
    sum = p ^ c;
  end
endmodule

// File: rtl/cla_sub16_pipe.sv
// cla_sub16_pipe: pipelined lookahead subtractor, one 4-bit slice per stage with skew/de-skew records
module cla_sub16_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / SLICE_W;
  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  logic   adv;
  assign adv = !st_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;
  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : g_st
      stage_t             src;
      stage_t             nxt;
      logic [SLICE_W-1:0] sum;
      logic               co;
      logic               gp;
      logic               gg;
      if (s == 0) begin : g_head
        // Idle cycles enter as all-zero bubbles so input pins never reach state.
        always_comb begin
          src = '0;
          src.valid = in_valid;
          src.carry = in_valid & ~bin;
          src.a[WIDTH-1:0] = in_valid ? a : '0;
          src.b[WIDTH-1:0] = in_valid ? b : '0;
        end
      end else begin : g_body
        assign src = st_q[s-1];
      end
      cla4_slice u_slice (
        .a     (src.a[s*SLICE_W +: SLICE_W]),
        .b     (~src.b[s*SLICE_W +: SLICE_W]),
        .cin   (src.carry),
        .sum   (sum),
        .cout  (co),
        .grp_p (gp),
        .grp_g (gg)
      );
      always_comb begin
        nxt = src;
        nxt.carry = co;
        nxt.diff[s*SLICE_W +: SLICE_W] = sum;
        assert (co == (gg | (gp & src.carry)));
      end
      assign st_d[s] = nxt;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '{default: '0};
    else if (adv) st_q <= st_d;
  end
  assign out_valid = st_q[STAGES-1].valid;
  assign diff = st_q[STAGES-1].diff[WIDTH-1:0];
  assign bout = st_q[STAGES-1].valid & ~st_q[STAGES-1].carry;
  assign zero = st_q[STAGES-1].valid & ~|st_q[STAGES-1].diff[WIDTH-1:0];
  assign ovf = st_q[STAGES-1].valid
             & (st_q[STAGES-1].a[WIDTH-1] ^ st_q[STAGES-1].b[WIDTH-1])
             & (st_q[STAGES-1].diff[WIDTH-1] ^ st_q[STAGES-1].a[WIDTH-1]);
endmodule
